bcd_timer_ctrl: RTL and testbench
=================================

BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 1, number of accepted TICK pulses per count step (legal 1..16).
REQ-002 Port: CLK  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: RST  in  1  reset, synchronous, active-high.
REQ-004 Port: START  in  1  start / resume request, level sampled each cycle.
REQ-005 Port: STOP  in  1  pause request, level sampled each cycle.
REQ-006 Port: CLEAR  in  1  abort to IDLE with count 00.
REQ-007 Port: TICK  in  1  count-enable strobe; one cycle high equals one tick.
REQ-008 Port: TGT_tens  in  4  target tens digit, BCD.
REQ-009 Port: TGT_ones  in  4  target ones digit, BCD.
REQ-010 Port: CNT_tens  out  4  current count, tens digit, BCD.
REQ-011 Port: CNT_ones  out  4  current count, ones digit, BCD.
REQ-012 Port: STATE  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-013 Port: BUSY  out  1  high exactly while STATE=RUN.
REQ-014 Port: DONE_P  out  1  one-cycle pulse on RUN->DONE transition.
REQ-015 Port: WRAP_P  out  1  one-cycle pulse on count step 99->00.

Function
REQ-016 Count SHALL be a two-digit BCD value 00..99; ones steps 0..9, carry into tens; 99 steps to 00 and asserts WRAP_P.
REQ-017 Command priority SHALL be CLEAR > STOP > START when asserted in the same cycle.
REQ-018 IDLE: count held at 00; START -> RUN next cycle, latching target and clearing prescaler.
REQ-019 Target latch: TGT digits >9 SHALL be clamped to 9 at latch; TGT changes after latch SHALL be ignored until next latch.
REQ-020 RUN: each TICK increments internal prescaler; when prescaler equals TICK_DIV-1 the count steps and prescaler returns to 0.
REQ-021 RUN: when a count step produces a value equal to the latched target, the block SHALL enter DONE the next cycle and assert DONE_P for exactly that cycle.
REQ-022 Target 00 SHALL complete after 100 steps (99->00 step asserts WRAP_P and DONE_P in the same cycle).
REQ-023 RUN: STOP -> PAUSE; a TICK in the same cycle as STOP SHALL be discarded (no prescaler or count change).
REQ-024 PAUSE: count and prescaler held; TICK ignored; START -> RUN without re-latching target or clearing prescaler.
REQ-025 DONE: count held at target; TICK ignored; START -> RUN with count cleared to 00, target re-latched, prescaler cleared; STOP ignored.
REQ-026 CLEAR in any state -> IDLE next cycle, count 00, prescaler 0, no DONE_P/WRAP_P.
REQ-027 START in RUN SHALL be ignored; STOP in IDLE SHALL be ignored.
REQ-028 Latency: count outputs reflect a step one cycle after the triggering TICK edge; STATE changes one cycle after command.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 While RST is high at a rising CLK edge: STATE=IDLE, CNT_tens=0, CNT_ones=0, BUSY=0, DONE_P=0, WRAP_P=0, prescaler=0, latched target=00.
REQ-031 RST SHALL override all commands and TICK, including mid-RUN and in the cycle a DONE_P would fire (DONE_P suppressed).

Verification
REQ-032 TICK_DIV=1, target 05, START then 5 TICKs -> count 01..05, DONE_P one cycle after 5th TICK, STATE=11, count holds 05 under further TICKs.
REQ-033 TICK_DIV=1, target 00, START then 100 TICKs -> count 99 after 99 TICKs; 100th TICK gives count 00, WRAP_P and DONE_P same cycle.
REQ-034 TICK_DIV=3, target 02, 6 TICKs with STOP+TICK collision after 4th, then START, 2 TICKs -> collision TICK discarded, PAUSE holds count 01, DONE reached after 6 accepted TICKs total.
REQ-035 Target ones=0xC latched as 9: target 1C, START, 19 TICKs -> DONE at count 19; TGT change mid-run has no effect.
REQ-036 CLEAR+STOP+START same cycle in RUN at count 37 -> IDLE, count 00, no pulses; RST asserted in RUN at count 42 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: two-digit BCD up-counter with a target compare, driven by a
// prescaled TICK strobe and START/STOP/CLEAR commands. Every output comes
// straight from a register, so nothing combinational reaches the ports.
module bcd_timer_ctrl #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       STOP,
   input  logic       CLEAR,
   input  logic       TICK,
   input  logic [3:0] TGT_tens,
   input  logic [3:0] TGT_ones,
   output logic [3:0] CNT_tens,
   output logic [3:0] CNT_ones,
   output logic [1:0] STATE,
   output logic       BUSY,
   output logic       DONE_P,
   output logic       WRAP_P
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   localparam logic [3:0] PRESC_LAST = 4'(TICK_DIV - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_tens_q, cnt_tens_d;
   logic [3:0] cnt_ones_q, cnt_ones_d;
   logic [3:0] presc_q, presc_d;
   logic [3:0] tgt_tens_q, tgt_tens_d;
   logic [3:0] tgt_ones_q, tgt_ones_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       wrap_q, wrap_d;

   logic [3:0] step_tens, step_ones;
   logic       step_wrap;
   logic [3:0] clamp_tens, clamp_ones;
   logic       cmd_stop, cmd_start;

   // Command priority: CLEAR masks STOP and START, STOP masks START.
   always_comb begin
      cmd_stop  = STOP & ~CLEAR;
      cmd_start = START & ~STOP & ~CLEAR;
   end

   // Target digits above 9 are not valid BCD; they latch as 9.
   always_comb begin
      clamp_tens = (TGT_tens > 4'd9) ? 4'd9 : TGT_tens;
      clamp_ones = (TGT_ones > 4'd9) ? 4'd9 : TGT_ones;
   end

   // Value the count would take on its next step, with carry and 99->00 wrap.
   always_comb begin
      step_ones = cnt_ones_q + 4'd1;
      step_tens = cnt_tens_q;
      step_wrap = 1'b0;
      if (cnt_ones_q == 4'd9) begin
         step_ones = 4'd0;
         if (cnt_tens_q == 4'd9) begin
            step_tens = 4'd0;
            step_wrap = 1'b1;
         end else begin
            step_tens = cnt_tens_q + 4'd1;
         end
      end
   end

   // Next-state, count, prescaler, target latch and pulse decisions.
   always_comb begin
      state_d    = state_q;
      cnt_tens_d = cnt_tens_q;
      cnt_ones_d = cnt_ones_q;
      presc_d    = presc_q;
      tgt_tens_d = tgt_tens_q;
      tgt_ones_d = tgt_ones_q;
      done_d     = 1'b0;
      wrap_d     = 1'b0;

      if (CLEAR) begin
         state_d    = ST_IDLE;
         cnt_tens_d = 4'd0;
         cnt_ones_d = 4'd0;
         presc_d    = 4'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_tens_d = 4'd0;
               cnt_ones_d = 4'd0;
               if (cmd_start) begin
                  state_d    = ST_RUN;
                  tgt_tens_d = clamp_tens;
                  tgt_ones_d = clamp_ones;
                  presc_d    = 4'd0;
               end
            end
            ST_RUN: begin
               if (cmd_stop) begin
                  state_d = ST_PAUSE;
               end else if (TICK) begin
                  if (presc_q == PRESC_LAST) begin
                     presc_d    = 4'd0;
                     cnt_tens_d = step_tens;
                     cnt_ones_d = step_ones;
                     wrap_d     = step_wrap;
                     if ((step_tens == tgt_tens_q) && (step_ones == tgt_ones_q)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                     end
                  end else begin
                     presc_d = presc_q + 4'd1;
                  end
               end
            end
            ST_PAUSE: begin
               if (cmd_start) begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               if (cmd_start) begin
                  state_d    = ST_RUN;
                  cnt_tens_d = 4'd0;
                  cnt_ones_d = 4'd0;
                  tgt_tens_d = clamp_tens;
                  tgt_ones_d = clamp_ones;
                  presc_d    = 4'd0;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d == ST_RUN);
   end

   // State and output registers; RST overrides every command and TICK.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         cnt_tens_q <= 4'd0;
         cnt_ones_q <= 4'd0;
         presc_q    <= 4'd0;
         tgt_tens_q <= 4'd0;
         tgt_ones_q <= 4'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_tens_q <= cnt_tens_d;
         cnt_ones_q <= cnt_ones_d;
         presc_q    <= presc_d;
         tgt_tens_q <= tgt_tens_d;
         tgt_ones_q <= tgt_ones_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wrap_q     <= wrap_d;
      end
   end

   assign STATE    = state_q;
   assign CNT_tens = cnt_tens_q;
   assign CNT_ones = cnt_ones_q;
   assign BUSY     = busy_q;
   assign DONE_P   = done_q;
   assign WRAP_P   = wrap_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: drives two timers (TICK_DIV=1 and TICK_DIV=3) from the
// same inputs and checks both every cycle against an arithmetic model of the
// timer, plus pinned literal values for the key scenarios.
module tb_bcd_timer_ctrl;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       START = 1'b0;
   logic       STOP = 1'b0;
   logic       CLEAR = 1'b0;
   logic       TICK = 1'b0;
   logic [3:0] TGT_tens = 4'd0;
   logic [3:0] TGT_ones = 4'd0;

   logic [3:0] cnt_tens1, cnt_ones1, cnt_tens3, cnt_ones3;
   logic [1:0] state1, state3;
   logic       busy1, done1, wrap1, busy3, done3, wrap3;
   logic [12:0] dut_vec [2];

   int checks = 0;
   int failures = 0;
   bit check_en = 1'b0;

   int m_state [2] = '{0, 0};
   int m_cnt   [2] = '{0, 0};
   int m_presc [2] = '{0, 0};
   int m_tgt   [2] = '{0, 0};
   bit m_done  [2] = '{1'b0, 1'b0};
   bit m_wrap  [2] = '{1'b0, 1'b0};
   int div_of  [2] = '{1, 3};

   bcd_timer_ctrl #(.TICK_DIV(1)) dut1 (
      .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .CLEAR(CLEAR), .TICK(TICK),
      .TGT_tens(TGT_tens), .TGT_ones(TGT_ones),
      .CNT_tens(cnt_tens1), .CNT_ones(cnt_ones1), .STATE(state1),
      .BUSY(busy1), .DONE_P(done1), .WRAP_P(wrap1)
   );

   bcd_timer_ctrl #(.TICK_DIV(3)) dut3 (
      .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .CLEAR(CLEAR), .TICK(TICK),
      .TGT_tens(TGT_tens), .TGT_ones(TGT_ones),
      .CNT_tens(cnt_tens3), .CNT_ones(cnt_ones3), .STATE(state3),
      .BUSY(busy3), .DONE_P(done3), .WRAP_P(wrap3)
   );

   assign dut_vec[0] = {state1, cnt_tens1, cnt_ones1, busy1, done1, wrap1};
   assign dut_vec[1] = {state3, cnt_tens3, cnt_ones3, busy3, done3, wrap3};

   // 10 ns clock.
   always #5 CLK = ~CLK;

   // Expected output vector from a state code and a plain decimal count.
   function automatic logic [12:0] lit(input int st, input int cnt, input bit dn, input bit wr);
      return {2'(st), 4'(cnt / 10), 4'(cnt % 10), (st == M_RUN), dn, wr};
   endfunction

   function automatic logic [12:0] modelVec(input int i);
      return lit(m_state[i], m_cnt[i], m_done[i], m_wrap[i]);
   endfunction

   // One clock of the timer behaviour, count kept as an integer 0..99.
   task automatic modelStep(input int i);
      int  tgt_new;
      bit  go;
      tgt_new = ((TGT_tens > 4'd9) ? 9 : int'(TGT_tens)) * 10
              + ((TGT_ones > 4'd9) ? 9 : int'(TGT_ones));
      go = START && !STOP;
      m_done[i] = 1'b0;
      m_wrap[i] = 1'b0;
      if (RST) begin
         m_state[i] = M_IDLE; m_cnt[i] = 0; m_presc[i] = 0; m_tgt[i] = 0;
      end else if (CLEAR) begin
         m_state[i] = M_IDLE; m_cnt[i] = 0; m_presc[i] = 0;
      end else if (m_state[i] == M_IDLE) begin
         if (go) begin
            m_state[i] = M_RUN; m_tgt[i] = tgt_new; m_presc[i] = 0;
         end
      end else if (m_state[i] == M_RUN) begin
         if (STOP) begin
            m_state[i] = M_PAUSE;
         end else if (TICK) begin
            if (m_presc[i] == div_of[i] - 1) begin
               m_presc[i] = 0;
               if (m_cnt[i] == 99) m_wrap[i] = 1'b1;
               m_cnt[i] = (m_cnt[i] + 1) % 100;
               if (m_cnt[i] == m_tgt[i]) begin
                  m_state[i] = M_DONE; m_done[i] = 1'b1;
               end
            end else begin
               m_presc[i] = m_presc[i] + 1;
            end
         end
      end else if (m_state[i] == M_PAUSE) begin
         if (go) m_state[i] = M_RUN;
      end else begin
         if (go) begin
            m_state[i] = M_RUN; m_cnt[i] = 0; m_tgt[i] = tgt_new; m_presc[i] = 0;
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [12:0] act, input logic [12:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h (state,tens,ones,busy,done,wrap)",
                  name, act, exp);
      end
   endtask

   // Pins both the DUT and the model of one instance to a hand-computed value.
   task automatic pinned(input string name, input int i, input logic [12:0] exp);
      checkOutput({name, "_dut"}, dut_vec[i], exp);
      checkOutput({name, "_model"}, modelVec(i), exp);
   endtask

   task automatic applyStimulus(input bit rst, input bit start, input bit stop,
                                input bit clear, input bit tick);
      @(negedge CLK);
      RST = rst; START = start; STOP = stop; CLEAR = clear; TICK = tick;
      @(posedge CLK);
      #2;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 1);
   endtask

   // Advance the model on every rising edge with the inputs the DUTs see.
   always @(posedge CLK) begin
      for (int i = 0; i < 2; i++) modelStep(i);
   end

   // Compare both instances against the model shortly after each edge.
   always @(posedge CLK) begin
      #1;
      if (check_en) begin
         checkOutput("cycle_div1", dut_vec[0], modelVec(0));
         checkOutput("cycle_div3", dut_vec[1], modelVec(1));
      end
   end

   initial begin
      bit r_rst, r_start, r_stop, r_clear, r_tick;

      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 1);
      check_en = 1'b1;
      pinned("reset", 0, lit(M_IDLE, 0, 0, 0));
      pinned("reset3", 1, lit(M_IDLE, 0, 0, 0));

      // Target 05, five ticks at TICK_DIV=1.
      TGT_tens = 4'd0; TGT_ones = 4'd5;
      applyStimulus(0, 1, 0, 0, 0);
      pinned("r032_start", 0, lit(M_RUN, 0, 0, 0));
      ticks(4);
      pinned("r032_four", 0, lit(M_RUN, 4, 0, 0));
      ticks(1);
      pinned("r032_done", 0, lit(M_DONE, 5, 1, 0));
      ticks(1);
      pinned("r032_hold", 0, lit(M_DONE, 5, 0, 0));
      applyStimulus(0, 0, 0, 1, 0);

      // Target 00 needs the full 100 steps and wraps as it completes.
      TGT_tens = 4'd0; TGT_ones = 4'd0;
      applyStimulus(0, 1, 0, 0, 0);
      ticks(99);
      pinned("r033_99", 0, lit(M_RUN, 99, 0, 0));
      ticks(1);
      pinned("r033_wrap", 0, lit(M_DONE, 0, 1, 1));
      applyStimulus(0, 0, 0, 1, 0);

      // TICK_DIV=3, target 02, STOP collides with a TICK.
      TGT_tens = 4'd0; TGT_ones = 4'd2;
      applyStimulus(0, 1, 0, 0, 0);
      ticks(4);
      pinned("r034_four", 1, lit(M_RUN, 1, 0, 0));
      applyStimulus(0, 0, 1, 0, 1);
      pinned("r034_pause", 1, lit(M_PAUSE, 1, 0, 0));
      ticks(1);
      pinned("r034_pause_tick", 1, lit(M_PAUSE, 1, 0, 0));
      applyStimulus(0, 1, 0, 0, 0);
      pinned("r034_resume", 1, lit(M_RUN, 1, 0, 0));
      ticks(1);
      pinned("r034_fifth", 1, lit(M_RUN, 1, 0, 0));
      ticks(1);
      pinned("r034_done", 1, lit(M_DONE, 2, 1, 0));
      applyStimulus(0, 0, 0, 1, 0);

      // Ones digit 0xC latches as 9; a later target change is ignored.
      TGT_tens = 4'd1; TGT_ones = 4'hC;
      applyStimulus(0, 1, 0, 0, 0);
      TGT_tens = 4'd0; TGT_ones = 4'd3;
      ticks(18);
      pinned("r035_18", 0, lit(M_RUN, 18, 0, 0));
      ticks(1);
      pinned("r035_done", 0, lit(M_DONE, 19, 1, 0));
      applyStimulus(0, 0, 0, 1, 0);

      // CLEAR beats STOP and START; RST beats everything.
      TGT_tens = 4'd9; TGT_ones = 4'd9;
      applyStimulus(0, 1, 0, 0, 0);
      ticks(37);
      pinned("r036_37", 0, lit(M_RUN, 37, 0, 0));
      applyStimulus(0, 1, 1, 1, 1);
      pinned("r036_clear", 0, lit(M_IDLE, 0, 0, 0));
      applyStimulus(0, 1, 0, 0, 0);
      ticks(42);
      pinned("r036_42", 0, lit(M_RUN, 42, 0, 0));
      applyStimulus(1, 1, 0, 0, 1);
      pinned("r036_rst", 0, lit(M_IDLE, 0, 0, 0));
      TGT_tens = 4'd0; TGT_ones = 4'd1;
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 1);
      pinned("rst_kills_done", 0, lit(M_IDLE, 0, 0, 0));

      // Randomized traffic, checked every cycle by the compare process.
      for (int n = 0; n < 4000; n++) begin
         r_rst   = ($urandom_range(0, 499) == 0);
         r_clear = ($urandom_range(0, 199) == 0);
         r_start = ($urandom_range(0, 5) == 0);
         r_stop  = !r_start && ($urandom_range(0, 19) == 0);
         r_tick  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) begin
            TGT_tens = 4'($urandom_range(0, 15));
            TGT_ones = 4'($urandom_range(0, 15));
         end
         applyStimulus(r_rst, r_start, r_stop, r_clear, r_tick);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
